datapath_seq_ctrl: RTL and testbench
====================================

Name: datapath_seq_ctrl

Overview:
- Control unit that sequences the single-bus datapath through fetch (T0–T2) and execute (T3–T6) for register-to-register ALU instructions.
- Drives every enable/select/read strobe and the 5-bit ALU opcode that the bench currently toggles by hand.
- Decodes the IR after fetch and waits on a memory-ready handshake during the fetch read.
- Reports completion, or an error for illegal opcodes and memory timeouts.

Parameters:
- MEM_WAIT_MAX, 15: maximum T1 cycles spent waiting for mem_ready before the instruction aborts (counter width 4 bits).
- NUM_REGS, 16: size of the general register file; width of the one-hot register select/enable buses.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin one instruction cycle; sampled only in IDLE.
- mem_ready  in  1  memory data valid on MDataIN during T1.
- IR_Data  in  32  instruction register contents from the datapath.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- error  out  1  valid with done; 1 = illegal opcode or memory timeout.
- reg_select  out  NUM_REGS  one-hot register-to-bus select.
- reg_enable  out  NUM_REGS  one-hot register write enable.
- PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, MDR_select, read, Z_LO_select, Z_HI_select, LO_enable, HI_enable  out  1 each  datapath strobes, same meaning as the datapath ports of the same name.
- alu_instruction  out  5  ALU opcode.

Behaviour:
- Clock and reset: one clock (clk). reset_n is synchronous and active-low: when reset_n=0 at a rising edge, state goes to IDLE, the wait counter clears and the error flag clears. This applies mid-instruction too.
- Outputs are decoded combinationally from the registered state (plus IR_Data and mem_ready where stated). In IDLE every output is 0, so every output is 0 after reset.
- IR fields:
  - op = IR_Data[31:27]
  - Ra = IR_Data[26:23]
  - Rb = IR_Data[22:19]
  - Rc = IR_Data[18:15]
- Instruction classes:
  - Three-register (ADD, SUB, AND, OR): Ra <= Rb op Rc.
  - Two-register (MUL, DIV): HI/LO <= Ra op Rb.
  - Unary (NEG, NOT): Ra <= op Rb.
  - Any other op is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- IDLE: start=1 -> T0. Otherwise stay. start is ignored in all other states.
- T0: PC_select, MAR_enable, PC_increment_enable, Z_enable. Next state T1.
- T1:
  - read is high for the whole state.
  - In the cycle where mem_ready=1: Z_LO_select, PC_enable and MDR_enable are also asserted, and the next state is T2.
  - While mem_ready=0 the wait counter increments. When the counter reaches MEM_WAIT_MAX, set error and go to DONE; PC and MDR are not written.
- T2: MDR_select, IR_enable. Next state T3.
- T3:
  - If op is illegal: set error, go to DONE with no strobes asserted.
  - Otherwise Y_enable is asserted with the following source on reg_select, then go to T4:
    - Three-register and unary: Rb.
    - Two-register: Ra.
- T4: Z_enable, alu_instruction=op, reg_select set as follows. Next state T5.
  - Three-register: Rc.
  - Two-register and unary: Rb.
- T5: Z_LO_select plus one write enable. Write-enables are never asserted outside T1, T2, T5 and T6.
  - Two-register: LO_enable, next state T6.
  - Others: reg_enable[Ra], next state DONE.
- T6: Z_HI_select, HI_enable. Next state DONE.
- DONE: done=1 and error held. Next state IDLE; error clears on leaving DONE.
- Latency with mem_ready high in T1: from the start edge, done is at cycle 8 for MUL/DIV and cycle 7 for other ops.
- Invariant: at most one bus source select is high in any cycle.
- alu_instruction is 0 outside T4.

Decomposition:
- Package datapath_pkg holds:
  - opcode constants: ADD=5'b00011, SUB=5'b00100, AND=5'b00101, OR=5'b00110, MUL=5'b01111, DIV=5'b10000, NEG=5'b10001, NOT=5'b10010;
  - the state encoding typedef;
  - the IR field bit positions.
- Sub-module ir_decode: combinational. Takes IR_Data; produces the class (three_reg / two_reg / unary / illegal), the Ra/Rb/Rc one-hot vectors and the opcode.

Test Plan:
- Reset, then DIV: preload R6=8, R7=3, mem_ready tied high, IR=32'h83380000, pulse start. Required: LO=2, HI=2; done at cycle 8 with error=0; strobe sequence matches T0–T6.
- ADD: R2=5, R3=7, IR encoding ADD R1,R2,R3. Required: R1=12; done at cycle 7; HI_enable and LO_enable never assert.
- Memory stall: mem_ready held low for 3 cycles in T1. Required: read stays high for 4 cycles; PC_enable and MDR_enable pulse exactly once, in the mem_ready cycle. Then a second test holds mem_ready low for 15 cycles. Required: done with error=1, PC unchanged.
- Illegal opcode: op=5'b11111. Required: done with error=1 immediately after T3; no reg_enable, LO_enable or HI_enable asserted.
- Reset mid-instruction: drive reset_n low during T4 of a MUL. Required: next edge in IDLE with all outputs 0, busy=0; Z-to-HI/LO writes never occur. A start issued after reset completes normally.
- Start while busy: a start pulse during T2 is ignored. Exactly one done pulse, then IDLE.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, IR field positions, state and class encodings for the sequencer
package datapath_pkg;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        C_THREE, C_TWO, C_UNARY, C_ILLEGAL
    } iclass_e;
endpackage

// File: rtl/ir_decode.sv
// ir_decode: splits the IR into opcode, instruction class and one-hot register selects
module ir_decode
    import datapath_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [31:0]         ir_i,
    output iclass_e             cls_o,
    output logic [4:0]          op_o,
    output logic [NUM_REGS-1:0] ra_o,
    output logic [NUM_REGS-1:0] rb_o,
    output logic [NUM_REGS-1:0] rc_o
);
    logic unused_bits;

    assign unused_bits = ^ir_i[RC_LSB-1:0];
    assign op_o  = ir_i[OP_MSB:OP_LSB];
    assign ra_o  = NUM_REGS'(1) << ir_i[RA_MSB:RA_LSB];
    assign rb_o  = NUM_REGS'(1) << ir_i[RB_MSB:RB_LSB];
    assign rc_o  = NUM_REGS'(1) << ir_i[RC_MSB:RC_LSB];
    assign cls_o = (op_o == OP_ADD || op_o == OP_SUB || op_o == OP_AND || op_o == OP_OR) ? C_THREE :
                   (op_o == OP_MUL || op_o == OP_DIV) ? C_TWO :
                   (op_o == OP_NEG || op_o == OP_NOT) ? C_UNARY : C_ILLEGAL;
endmodule

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: fetch/execute sequencer driving the single-bus datapath strobes
// for register-to-register ALU instructions, with memory-timeout and illegal-op error.
module datapath_seq_ctrl
    import datapath_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int NUM_REGS     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         IR_Data,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [NUM_REGS-1:0] reg_select,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic                PC_select,
    output logic                PC_enable,
    output logic                PC_increment_enable,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                Z_enable,
    output logic                MAR_enable,
    output logic                MDR_enable,
    output logic                MDR_select,
    output logic                read,
    output logic                Z_LO_select,
    output logic                Z_HI_select,
    output logic                LO_enable,
    output logic                HI_enable,
    output logic [4:0]          alu_instruction
);
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    iclass_e             cls;
    logic [4:0]          op;
    logic [NUM_REGS-1:0] ra, rb, rc;

    ir_decode #(.NUM_REGS(NUM_REGS)) u_dec (
        .ir_i (IR_Data),
        .cls_o(cls),
        .op_o (op),
        .ra_o (ra),
        .rb_o (rb),
        .rc_o (rc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy = state_q != S_IDLE;

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        err_d               = err_q;
        done                = 1'b0;
        error               = 1'b0;
        reg_select          = '0;
        reg_enable          = '0;
        PC_select           = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        MDR_select          = 1'b0;
        read                = 1'b0;
        Z_LO_select         = 1'b0;
        Z_HI_select         = 1'b0;
        LO_enable           = 1'b0;
        HI_enable           = 1'b0;
        alu_instruction     = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = start ? S_T0 : S_IDLE;
            end
            S_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
                state_d             = S_T1;
            end
            S_T1: begin
                read        = 1'b1;
                Z_LO_select = mem_ready;
                PC_enable   = mem_ready;
                MDR_enable  = mem_ready;
                cnt_d       = mem_ready ? cnt_q : cnt_q + 4'd1;
                // the cycle that brings the counter to the limit is the last one allowed
                err_d       = !mem_ready && cnt_d == 4'(MEM_WAIT_MAX);
                state_d     = mem_ready ? S_T2 : (err_d ? S_DONE : S_T1);
            end
            S_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                err_d      = cls == C_ILLEGAL;
                Y_enable   = cls != C_ILLEGAL;
                reg_select = cls == C_ILLEGAL ? '0 : (cls == C_TWO ? ra : rb);
                state_d    = cls == C_ILLEGAL ? S_DONE : S_T4;
            end
            S_T4: begin
                Z_enable        = 1'b1;
                alu_instruction = op;
                reg_select      = cls == C_THREE ? rc : rb;
                state_d         = S_T5;
            end
            S_T5: begin
                Z_LO_select = 1'b1;
                LO_enable   = cls == C_TWO;
                reg_enable  = cls == C_TWO ? '0 : ra;
                state_d     = cls == C_TWO ? S_T6 : S_DONE;
            end
            S_T6: begin
                Z_HI_select = 1'b1;
                HI_enable   = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                error   = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl: sequencer driving a behavioural single-bus datapath; scoreboarded
// per-instruction results and a per-cycle strobe signature for the first instruction.
module tb_datapath_seq_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, mem_ready = 1'b0;
    logic [31:0] IR_Data;
    logic        busy, done, error;
    logic [15:0] reg_select, reg_enable;
    logic        PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, MDR_select, read, Z_LO_select, Z_HI_select;
    logic        LO_enable, HI_enable;
    logic [4:0]  alu_instruction;

    always #5 clk = ~clk;

    datapath_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mem_ready(mem_ready), .IR_Data(IR_Data),
        .busy(busy), .done(done), .error(error), .reg_select(reg_select), .reg_enable(reg_enable),
        .PC_select(PC_select), .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
        .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .MDR_select(MDR_select), .read(read), .Z_LO_select(Z_LO_select),
        .Z_HI_select(Z_HI_select), .LO_enable(LO_enable), .HI_enable(HI_enable),
        .alu_instruction(alu_instruction)
    );

    // behavioural datapath
    logic [31:0] r_m [16];
    logic [31:0] mem [256];
    logic [31:0] pc_m = '0, mar_m = '0, mdr_m = '0, ir_m = '0, y_m = '0, lo_m = '0, hi_m = '0;
    logic [63:0] z_m = '0;
    logic [31:0] bus;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;

    assign IR_Data = ir_m;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'b00011: return {32'b0, a + b};
            5'b00100: return {32'b0, a - b};
            5'b00101: return {32'b0, a & b};
            5'b00110: return {32'b0, a | b};
            5'b01111: return {32'b0, a} * {32'b0, b};
            5'b10000: return {a % b, a / b};
            5'b10001: return {32'b0, -b};
            5'b10010: return {32'b0, ~b};
            default:  return 64'b0;
        endcase
    endfunction

    always_comb begin
        bus = '0;
        if (PC_select) bus = pc_m;
        else if (MDR_select) bus = mdr_m;
        else if (Z_LO_select) bus = z_m[31:0];
        else if (Z_HI_select) bus = z_m[63:32];
        else for (int i = 0; i < 16; i++) if (reg_select[i]) bus = r_m[i];
    end

    always @(posedge clk) begin
        if (PC_enable) pc_m <= bus;
        if (MAR_enable) mar_m <= bus;
        if (MDR_enable) mdr_m <= mem[mar_m[7:0]];
        if (IR_enable) ir_m <= bus;
        if (Y_enable) y_m <= bus;
        if (Z_enable) z_m <= PC_increment_enable ? {32'b0, bus + 32'd1} : alu(alu_instruction, y_m, bus);
        if (LO_enable) lo_m <= bus;
        if (HI_enable) hi_m <= bus;
        for (int i = 0; i < 16; i++) if (reg_enable[i]) r_m[i] <= bus;
        if (ld_en) begin
            if (ld_idx == 5'd16) lo_m <= ld_val;
            else if (ld_idx == 5'd17) hi_m <= ld_val;
            else r_m[ld_idx[3:0]] <= ld_val;
        end
    end

    typedef struct {int lat; bit err; int reads; int pce; int hilo; int rege;} exp_t;
    exp_t        sb[$];
    logic [15:0] sig_q[$];
    int          checks = 0, passes = 0;

    function automatic logic [15:0] sig();
        return {PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                MDR_enable, MDR_select, read, Z_LO_select, Z_HI_select, LO_enable, HI_enable, done, error};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic load(input logic [4:0] idx, input logic [31:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input int lat, input bit err, input int reads, input int pce, input int hilo, input int rege);
        exp_t e;
        e.lat = lat; e.err = err; e.reads = reads; e.pce = pce; e.hilo = hilo; e.rege = rege;
        sb.push_back(e);
    endtask

    task automatic run(input logic [31:0] instr, input int stall, input bit restart);
        int   lat = 0, reads = 0, pce = 0, mdre = 0, hilo = 0, rege = 0, bad = 0, ndone = 0, viol = 0;
        logic errv = 1'b0;
        exp_t e;
        mem[pc_m[7:0]] = instr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 60 && (lat == 0 || n <= lat + 3); n++) begin
            if (n > 1) @(negedge clk);
            mem_ready = reads >= stall;
            start = restart && n == 3;
            #1;
            if (read) reads++;
            if (PC_enable) pce++;
            if (MDR_enable) mdre++;
            if (HI_enable) hilo++;
            if (LO_enable) hilo++;
            if (reg_enable != 0) rege++;
            if ((PC_enable || MDR_enable) && !mem_ready) bad++;
            if ($countones({PC_select, MDR_select, Z_LO_select, Z_HI_select}) + $countones(reg_select) > 1) viol++;
            if (done) begin
                ndone++;
                if (lat == 0) begin lat = n; errv = error; end
            end
            if (sig_q.size() > 0) chk("strobe_sig", sig(), sig_q.pop_front());
        end
        start = 1'b0;
        mem_ready = 1'b0;
        e = sb.pop_front();
        chk("done_cycle", lat, e.lat);
        chk("error", errv, e.err);
        chk("read_cycles", reads, e.reads);
        chk("pc_enable_cnt", pce, e.pce);
        chk("mdr_enable_cnt", mdre, e.pce);
        chk("hilo_writes", hilo, e.hilo);
        chk("reg_writes", rege, e.rege);
        chk("write_without_ready", bad, 0);
        chk("bus_conflict", viol, 0);
        chk("done_pulses", ndone, 1);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        logic [31:0] pc0;
        bit          t4;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {sig(), reg_select, reg_enable, alu_instruction}, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        load(5'd2, 32'd5); load(5'd3, 32'd7); load(5'd6, 32'd8); load(5'd7, 32'd3);

        // DIV R6,R7 with per-cycle strobe signature T0..T6, DONE
        sig_q = '{16'hA600, 16'h4160, 16'h1080, 16'h0800, 16'h0400, 16'h0028, 16'h0014, 16'h0002};
        push_exp(8, 0, 1, 1, 2, 0);
        run(32'h83380000, 0, 0);
        chk("div_lo", lo_m, 32'd2);
        chk("div_hi", hi_m, 32'd2);

        push_exp(7, 0, 1, 1, 0, 1);
        run(enc(5'b00011, 4'd1, 4'd2, 4'd3), 0, 0);
        chk("add_r1", r_m[1], 32'd12);

        push_exp(10, 0, 4, 1, 0, 1);
        run(enc(5'b00011, 4'd8, 4'd1, 4'd3), 3, 0);
        chk("stall_add_r8", r_m[8], 32'd19);

        pc0 = pc_m;
        push_exp(17, 1, 15, 0, 0, 0);
        run(enc(5'b00011, 4'd9, 4'd1, 4'd3), 15, 0);
        chk("timeout_pc_hold", pc_m, pc0);

        push_exp(5, 1, 1, 1, 0, 0);
        run({5'b11111, 27'b0}, 0, 0);

        push_exp(7, 0, 1, 1, 0, 1);
        run(enc(5'b00100, 4'd4, 4'd3, 4'd2), 0, 1);
        chk("sub_r4", r_m[4], 32'd2);

        push_exp(7, 0, 1, 1, 0, 1);
        run(enc(5'b10010, 4'd5, 4'd3, 4'd0), 0, 0);
        chk("not_r5", r_m[5], 32'hFFFF_FFF8);

        // reset while a MUL sits in T4
        load(5'd16, 32'hAAAA); load(5'd17, 32'h5555);
        mem[pc_m[7:0]] = enc(5'b01111, 4'd6, 4'd7, 4'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t4 = 0;
        for (int n = 0; n < 10 && !t4; n++) begin
            mem_ready = 1'b1;
            #1;
            if (Z_enable && !PC_increment_enable) t4 = 1;
            else @(negedge clk);
        end
        chk("mul_reached_t4", t4, 1);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_outs", {sig(), reg_select, reg_enable, alu_instruction}, 0);
        chk("midrst_busy", busy, 0);
        reset_n = 1'b1;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_lo", lo_m, 32'hAAAA);
        chk("midrst_hi", hi_m, 32'h5555);

        push_exp(8, 0, 1, 1, 2, 0);
        run(enc(5'b01111, 4'd6, 4'd7, 4'd0), 0, 0);
        chk("mul_lo", lo_m, 32'd24);
        chk("mul_hi", hi_m, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
